// File: rtl/des_key_schedule_gen_pkg.sv
// Shared DES key-schedule types, permutation tables and the 28-bit rotator.
// DES numbers bits from 1 at the MSB, so table entry n maps to vector bit (W - n).
package des_key_schedule_gen_pkg;

    typedef logic [63:0] key64_t;
    typedef logic [27:0] half28_t;
    typedef logic [55:0] cd56_t;
    typedef logic [47:0] subkey48_t;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

    // Permuted choice 1: 64-bit key -> {C0, D0}; parity bits never appear.
    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: {Cn, Dn} -> 48-bit round subkey Kn.
    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-shift amount applied to produce subkey n+1 is SHIFT_TBL[n] (0-based).
    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Rotate a 28-bit half by 0, 1 or 2 places; dir selects left or right.
    function automatic half28_t rot28(input half28_t v, input logic [1:0] amt, input logic dir);
        half28_t r;
        r = v;
        case ({dir, amt})
            3'b0_01: r = {v[26:0], v[27]};
            3'b0_10: r = {v[25:0], v[27:26]};
            3'b1_01: r = {v[0], v[27:1]};
            3'b1_10: r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_key_schedule_gen_if.sv
// Key-in / subkey-out handshake bundle for the DES key scheduler.
interface des_key_schedule_gen_if;
    import des_key_schedule_gen_pkg::*;

    key64_t    key_in;
    logic      key_decrypt;
    logic      key_valid;
    logic      key_ready;
    subkey48_t subkey_out;
    logic [3:0] subkey_idx;
    logic      subkey_last;
    logic      subkey_valid;
    logic      subkey_ready;

    // Key source and subkey consumer side.
    modport master (
        output key_in, key_decrypt, key_valid, subkey_ready,
        input  key_ready, subkey_out, subkey_idx, subkey_last, subkey_valid
    );

    // Scheduler side.
    modport slave (
        input  key_in, key_decrypt, key_valid, subkey_ready,
        output key_ready, subkey_out, subkey_idx, subkey_last, subkey_valid
    );

endinterface

// File: rtl/des_key_schedule_gen_pc2_perm.sv
// Combinational PC-2: {C,D} (56 bits) -> 48-bit subkey. Pure wiring.
module des_key_schedule_gen_pc2_perm
    import des_key_schedule_gen_pkg::*;
(
    input  cd56_t     cd,
    output subkey48_t subkey
);

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        localparam logic [5:0] SRC = 6'(56 - PC2_TBL[i]);
        localparam logic [5:0] DST = 6'(47 - i);
        assign subkey[DST] = cd[SRC];
    end

    // PC-2 discards {C,D} bits 9,18,22,25,35,38,43,54.
    logic dropped_unused;
    assign dropped_unused = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule_gen.sv
// DES key scheduler: accepts a 64-bit key and streams K1..K16 (encrypt)
// or K16..K1 (decrypt), one subkey per cycle under valid/ready.
// Decrypt order walks C/D backwards with right rotations, so no subkey RAM.
module des_key_schedule_gen
    import des_key_schedule_gen_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    des_key_schedule_gen_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0] state;
    half28_t    c_q;
    half28_t    d_q;
    logic [3:0] count_q;
    logic       dir_q;

    subkey48_t  sub_out_p1;
    logic [3:0] sub_idx_p1;
    logic       sub_last_p1;
    logic       vld_p1;

    cd56_t      cd_load;
    half28_t    c_nxt;
    half28_t    d_nxt;
    logic [3:0] idx_nxt;
    logic [1:0] amt;
    logic       accept;
    logic       handshake;
    subkey48_t  pc2_out;

    // PC-1 is fixed wiring from the key port into {C0, D0}.
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        localparam logic [5:0] SRC = 6'(64 - PC1_TBL[i]);
        localparam logic [5:0] DST = 6'(55 - i);
        assign cd_load[DST] = bus.key_in[SRC];
    end

    // Parity bits 8,16,..,64 carry no key material.
    logic key_parity_unused;
    assign key_parity_unused = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40], bus.key_in[32],
                                 bus.key_in[24], bus.key_in[16], bus.key_in[8],  bus.key_in[0]};

    assign bus.key_ready    = (state == ST_IDLE);
    assign bus.subkey_out   = sub_out_p1;
    assign bus.subkey_idx   = sub_idx_p1;
    assign bus.subkey_last  = sub_last_p1;
    assign bus.subkey_valid = vld_p1;

    // Next C/D and subkey index: load from PC-1 on accept, otherwise step one subkey per handshake.
    always_comb begin
        accept    = (state == ST_IDLE) && bus.key_valid;
        handshake = (state == ST_EMIT) && vld_p1 && bus.subkey_ready;
        c_nxt     = c_q;
        d_nxt     = d_q;
        idx_nxt   = sub_idx_p1;
        amt       = 2'd0;
        if (accept) begin
            if (bus.key_decrypt) begin
                // C16/D16 equal C0/D0: the shifts total 28, a full turn.
                c_nxt   = cd_load[55:28];
                d_nxt   = cd_load[27:0];
                idx_nxt = 4'd15;
            end else begin
                amt     = SHIFT_TBL[0];
                c_nxt   = rot28(cd_load[55:28], amt, ROT_LEFT);
                d_nxt   = rot28(cd_load[27:0], amt, ROT_LEFT);
                idx_nxt = 4'd0;
            end
        end else if (handshake && (count_q != 4'd15)) begin
            if (dir_q) begin
                // Undo the shift that produced the current subkey.
                amt     = SHIFT_TBL[sub_idx_p1];
                c_nxt   = rot28(c_q, amt, ROT_RIGHT);
                d_nxt   = rot28(d_q, amt, ROT_RIGHT);
                idx_nxt = sub_idx_p1 - 4'd1;
            end else begin
                amt     = SHIFT_TBL[sub_idx_p1 + 4'd1];
                c_nxt   = rot28(c_q, amt, ROT_LEFT);
                d_nxt   = rot28(d_q, amt, ROT_LEFT);
                idx_nxt = sub_idx_p1 + 4'd1;
            end
        end
    end

    des_key_schedule_gen_pc2_perm u_pc2 (
        .cd     ({c_nxt, d_nxt}),
        .subkey (pc2_out)
    );

    // FSM, C/D state and registered subkey outputs; everything holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            c_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            sub_out_p1  <= '0;
            sub_idx_p1  <= '0;
            sub_last_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        c_q         <= c_nxt;
                        d_q         <= d_nxt;
                        dir_q       <= bus.key_decrypt;
                        count_q     <= 4'd0;
                        sub_out_p1  <= pc2_out;
                        sub_idx_p1  <= idx_nxt;
                        sub_last_p1 <= 1'b0;
                        vld_p1      <= 1'b1;
                        state       <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (handshake) begin
                        if (count_q == 4'd15) begin
                            vld_p1      <= 1'b0;
                            sub_last_p1 <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            count_q     <= count_q + 4'd1;
                            c_q         <= c_nxt;
                            d_q         <= d_nxt;
                            sub_out_p1  <= pc2_out;
                            sub_idx_p1  <= idx_nxt;
                            sub_last_p1 <= (count_q == 4'd14);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule_gen.sv
// Scoreboard bench for des_key_schedule_gen: stimulus queues expected
// subkeys, a negedge monitor pops and compares on every handshake.
module tb_des_key_schedule_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    des_key_schedule_gen_if bus ();

    des_key_schedule_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_PAR = 64'h0101010101010101;

    // K1..K16 for KEY_A, worked by hand through PC-1, shifts and PC-2.
    logic [47:0] kexp [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_seq(input logic dec, input logic zero);
        exp_t e;
        for (int n = 0; n < 16; n++) begin
            e.idx  = dec ? 4'(15 - n) : 4'(n);
            e.sk   = zero ? 48'h0 : kexp[e.idx];
            e.last = (n == 15);
            exp_q.push_back(e);
        end
    endtask

    // Present a key and wait for it to be taken; key_valid is left high.
    task automatic issue_key(input logic [63:0] key, input logic dec, input logic zero,
                             output int acc_cyc);
        logic ok;
        logic [47:0] first;
        bus.key_in      = key;
        bus.key_decrypt = dec;
        bus.key_valid   = 1'b1;
        ok = 1'b0;
        acc_cyc = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.key_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("key_accept_timeout", 64'd0, 64'd1);
        end else begin
            push_seq(dec, zero);
            first = zero ? 48'h0 : kexp[dec ? 15 : 0];
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            chk("first_valid_latency", 64'(bus.subkey_valid), 64'd1);
            chk("first_subkey", 64'(bus.subkey_out), 64'(first));
            chk("ready_low_in_emit", 64'(bus.key_ready), 64'd0);
        end
    endtask

    task automatic wait_drain(input int limit);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("valid_drop_after_last", 64'(bus.subkey_valid), 64'd0);
        chk("ready_back_after_last", 64'(bus.key_ready), 64'd1);
    endtask

    // Monitor: compare each accepted subkey, and check outputs hold while stalled.
    initial begin : monitor
        logic  hold_v;
        exp_t  held;
        exp_t  got;
        exp_t  want;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                got = '{sk: bus.subkey_out, idx: bus.subkey_idx, last: bus.subkey_last};
                if (hold_v)
                    chk("stall_hold", 64'({bus.subkey_valid, got}), 64'({1'b1, held}));
                if (bus.subkey_valid && bus.subkey_ready) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_subkey", 64'(got), 64'd0);
                        n_fail += (got == '0) ? 1 : 0;
                    end else begin
                        want = exp_q.pop_front();
                        chk("sb_subkey_idx_last", 64'(got), 64'(want));
                    end
                end else if (bus.subkey_valid) begin
                    hold_v = 1'b1;
                    held   = got;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int ca;
        int cb;
        logic ok;

        bus.key_in       = '0;
        bus.key_decrypt  = 1'b0;
        bus.key_valid    = 1'b0;
        bus.subkey_ready = 1'b1;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
        chk("rst_subkey", 64'(bus.subkey_out), 64'd0);
        chk("rst_idx", 64'(bus.subkey_idx), 64'd0);
        chk("rst_last", 64'(bus.subkey_last), 64'd0);
        #18 rst = 1'b0;

        // Test 1: encrypt, ready high
        @(posedge clk); #1;
        issue_key(KEY_A, 1'b0, 1'b0, ca);
        bus.key_valid = 1'b0;
        wait_drain(100);

        // Test 2: decrypt, same key
        issue_key(KEY_A, 1'b1, 1'b0, ca);
        bus.key_valid = 1'b0;
        wait_drain(100);

        // Test 3: random backpressure, both directions
        for (int d = 0; d < 2; d++) begin
            bus.subkey_ready = 1'b0;
            issue_key(KEY_A, d[0], 1'b0, ca);
            bus.key_valid = 1'b0;
            for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
                @(posedge clk); #1;
                bus.subkey_ready = 1'($urandom_range(0, 1));
            end
            bus.subkey_ready = 1'b1;
            wait_drain(100);
        end

        // Test 4: key_valid held through EMIT with a different key
        issue_key(KEY_A, 1'b0, 1'b0, ca);
        issue_key(KEY_PAR, 1'b0, 1'b1, cb);
        bus.key_valid = 1'b0;
        chk("second_key_spacing", 64'(cb - ca), 64'd17);
        wait_drain(100);

        // Test 5: async reset while subkey 7 is on the port
        issue_key(KEY_A, 1'b0, 1'b0, ca);
        bus.key_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.subkey_valid && bus.subkey_idx == 4'd7) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_idx7", 64'(ok), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.subkey_valid), 64'd0);
        chk("midrst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("midrst_idx", 64'(bus.subkey_idx), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("no_partial_after_rst", 64'(bus.subkey_valid), 64'd0);
        end
        issue_key(KEY_A, 1'b1, 1'b0, ca);
        bus.key_valid = 1'b0;
        wait_drain(100);

        // Test 6: all-zero and parity-only keys
        issue_key(64'h0, 1'b0, 1'b1, ca);
        bus.key_valid = 1'b0;
        wait_drain(100);
        issue_key(KEY_PAR, 1'b1, 1'b1, ca);
        bus.key_valid = 1'b0;
        wait_drain(100);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
